// File: rtl/ldc_pkg.sv
// ldc_pkg: shared types, constants and configuration checks for line_delay_ctrl.
// Optional feature macro used by the block: LDC_FIRST_LINE_ZERO_EN.
package ldc_pkg;

   // Input-to-output latency of line_delay_ctrl in clock cycles.
   localparam int LDC_LATENCY  = 2;
   // Default pixel width; the pair type below packs two such pixels {hi, lo}.
   localparam int LDC_PIX_BITS = 8;

   typedef logic [2*LDC_PIX_BITS-1:0] ldc_pair_t;

   // Column parity: even pixels read the previous line, odd pixels write the pair.
   typedef enum logic {
      PH_EVEN = 1'b0,
      PH_ODD  = 1'b1
   } ldc_phase_t;

   // Ceiling log2 for constant (elaboration-time) sizing.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // A line must split into whole pixel pairs.
   function automatic bit ldc_width_ok(input int line_width);
      return (line_width >= 2) && ((line_width % 2) == 0);
   endfunction

   // The RAM must hold one word per pixel pair.
   function automatic bit ldc_addr_ok(input int line_width, input int addr_bits);
      return (64'(1) << addr_bits) >= 64'(line_width / 2);
   endfunction

endpackage

// File: rtl/spram_generic.sv
// spram_generic: single-port RAM, registered output, write-first on a write cycle.
// dout holds its value while en is low.
module spram_generic
   import ldc_pkg::*;
#(
   parameter int DATA_BITS   = 16,
   parameter int ADDR_AMOUNT = 320,
   parameter int ADDR_BITS   = 9
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout
);

   logic [DATA_BITS-1:0] mem [ADDR_AMOUNT];

   // Single port access: a write also returns the written word on dout.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= din;
            dout      <= din;
         end else begin
            dout <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/line_delay_ctrl.sv
// line_delay_ctrl: one-line pixel delay using a pair-packed single-port RAM.
// Even columns read the previous line's pair word; odd columns write the pair
// {odd, even} of the current line. Output latency is LDC_LATENCY cycles.
// Optional: LDC_FIRST_LINE_ZERO_EN forces dout_dly to 0 while first_line=1.
module line_delay_ctrl
   import ldc_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int LINE_WIDTH = 640,
   parameter int ADDR_BITS  = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frm_start,
   input  logic                 din_vld,
   input  logic [DATA_BITS-1:0] din,
   output logic                 dout_vld,
   output logic [DATA_BITS-1:0] dout_cur,
   output logic [DATA_BITS-1:0] dout_dly,
   output logic                 first_line
);

   localparam int COL_BITS  = (clog2(LINE_WIDTH) < 1) ? 1 : clog2(LINE_WIDTH);
   localparam int PAIR_BITS = 2 * DATA_BITS;
   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(LINE_WIDTH - 1);

   if (!ldc_width_ok(LINE_WIDTH)) begin : g_bad_width
      $error("line_delay_ctrl: LINE_WIDTH must be even and >= 2");
   end
   if (!ldc_addr_ok(LINE_WIDTH, ADDR_BITS)) begin : g_bad_addr
      $error("line_delay_ctrl: ADDR_BITS too small for LINE_WIDTH/2 pair words");
   end

   // column / line-0 state
   logic [COL_BITS-1:0]  col, col_eff, col_nxt;
   logic                 line0, line0_eff, line0_nxt;
   ldc_phase_t           phase;
   logic                 acc;

   // RAM port
   logic                 ram_en, ram_we;
   logic [ADDR_BITS-1:0] ram_addr;
   logic [PAIR_BITS-1:0] ram_din, ram_dout;

   // pipeline
   logic                 vld_p0, rd_p0, odd_p0, first_p0;
   logic [DATA_BITS-1:0] cur_p0, hold_lo, prev_hi;
   logic [DATA_BITS-1:0] dly_raw, dly_nxt;

   spram_generic #(
      .DATA_BITS   (PAIR_BITS),
      .ADDR_AMOUNT (LINE_WIDTH / 2),
      .ADDR_BITS   (ADDR_BITS)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   // Next column/line state and RAM command; frm_start retargets the current pixel to column 0.
   always_comb begin
      col_eff   = frm_start ? '0 : col;
      line0_eff = frm_start | line0;
      phase     = ldc_phase_t'(col_eff[0]);
      acc       = din_vld & ~rst;
      col_nxt   = col_eff;
      line0_nxt = line0_eff;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = ADDR_BITS'(col_eff >> 1);
      ram_din   = {din, hold_lo};
      if (acc) begin
         ram_en = 1'b1;
         ram_we = (phase == PH_ODD);
         if (col_eff == COL_LAST) begin
            col_nxt   = '0;
            line0_nxt = 1'b0;
         end else begin
            col_nxt = col_eff + 1'b1;
         end
      end
   end

   // Column and line-0 state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         col   <= '0;
         line0 <= 1'b1;
      end else begin
         col   <= col_nxt;
         line0 <= line0_nxt;
      end
   end

   // Stage p0: accepted pixel, its parity/line tag, and the even-pixel hold register.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0   <= 1'b0;
         rd_p0    <= 1'b0;
         odd_p0   <= 1'b0;
         first_p0 <= 1'b1;
         cur_p0   <= '0;
         hold_lo  <= '0;
      end else begin
         vld_p0 <= acc;
         rd_p0  <= acc & (phase == PH_EVEN);
         if (acc) begin
            cur_p0   <= din;
            odd_p0   <= (phase == PH_ODD);
            first_p0 <= line0_eff;
            if (phase == PH_EVEN) hold_lo <= din;
         end
      end
   end

   // Delayed-pixel select: even outputs take the fresh read low half, odd outputs the saved high half.
   always_comb begin
      dly_raw = odd_p0 ? prev_hi : ram_dout[DATA_BITS-1:0];
`ifdef LDC_FIRST_LINE_ZERO_EN
      dly_nxt = first_p0 ? '0 : dly_raw;
`else
      dly_nxt = dly_raw;
`endif
   end

   // Stage p1: output registers; read capture keyed on rd_p0 so write-first data is never taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_vld   <= 1'b0;
         dout_cur   <= '0;
         dout_dly   <= '0;
         first_line <= 1'b1;
         prev_hi    <= '0;
      end else begin
         dout_vld <= vld_p0;
         if (vld_p0) begin
            dout_cur   <= cur_p0;
            dout_dly   <= dly_nxt;
            first_line <= first_p0;
         end
         if (rd_p0) prev_hi <= ram_dout[PAIR_BITS-1:DATA_BITS];
      end
   end

endmodule

// File: tb/tb_line_delay_ctrl.sv
// tb_line_delay_ctrl: directed bench for line_delay_ctrl with LINE_WIDTH=4.
// Pixel values v=1..12 encode position: line (v-1)/4, column (v-1)%4.
module tb_line_delay_ctrl;
   import ldc_pkg::*;

   localparam int DW = 8;
   localparam int LW = 4;
   localparam int AB = 1;

`ifdef LDC_FIRST_LINE_ZERO_EN
   localparam logic L0_CHK = 1'b1;
`else
   localparam logic L0_CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, frm_start, din_vld;
   logic [DW-1:0] din;
   logic          dout_vld, first_line;
   logic [DW-1:0] dout_cur, dout_dly;

   always #5 clk = ~clk;

   line_delay_ctrl #(.DATA_BITS(DW), .LINE_WIDTH(LW), .ADDR_BITS(AB)) dut (
      .clk        (clk),
      .rst        (rst),
      .frm_start  (frm_start),
      .din_vld    (din_vld),
      .din        (din),
      .dout_vld   (dout_vld),
      .dout_cur   (dout_cur),
      .dout_dly   (dout_dly),
      .first_line (first_line)
   );

   typedef struct {
      logic          frm;
      logic          vld;
      logic [DW-1:0] pix;
      logic          ev;
      logic [DW-1:0] ec;
      logic [DW-1:0] ed;
      logic          ef;
      logic          cd;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push(input logic f, input logic v, input int p);
      vec_t r;
      r.frm = f; r.vld = v; r.pix = DW'(p);
      r.ev = 1'b0; r.ec = '0; r.ed = '0; r.ef = 1'b1; r.cd = 1'b0;
      tbl.push_back(r);
   endtask

   // One clock: drive after the rising edge, sample at the falling edge.
   task automatic cyc(input logic r, input logic f, input logic v, input int p);
      @(posedge clk);
      #1;
      rst = r; frm_start = f; din_vld = v; din = v ? DW'(p) : '0;
      @(negedge clk);
   endtask

   task automatic expect_out(input string name, input logic ev, input int ec, input int ed,
                             input logic ef, input logic cd);
      chk({name, ".vld"}, int'(dout_vld), int'(ev));
      if (ev) begin
         chk({name, ".cur"}, int'(dout_cur), ec);
         chk({name, ".first"}, int'(first_line), int'(ef));
         if (cd) chk({name, ".dly"}, int'(dout_dly), ed);
      end
   endtask

   initial begin
      rst = 1'b1; frm_start = 1'b0; din_vld = 1'b0; din = '0;

      // Continuous stream, three lines.
      push(1'b1, 1'b1, 1);
      for (int v = 2; v <= 12; v++) push(1'b0, 1'b1, v);
      push(1'b0, 1'b0, 0); push(1'b0, 1'b0, 0);
      // Same stream with a 3-cycle gap between the even and odd pixel of each pair.
      for (int v = 1; v <= 12; v++) begin
         push(v == 1, 1'b1, v);
         if (v % 2 == 1) begin
            push(1'b0, 1'b0, 0); push(1'b0, 1'b0, 0); push(1'b0, 1'b0, 0);
         end
      end
      push(1'b0, 1'b0, 0); push(1'b0, 1'b0, 0);

      // Expected outputs: the input two rows earlier; line n pairs with the value 4 below.
      for (int k = 2; k < tbl.size(); k++) begin
         tbl[k].ev = tbl[k-2].vld;
         if (tbl[k-2].vld) begin
            tbl[k].ec = tbl[k-2].pix;
            tbl[k].ef = (tbl[k-2].pix <= 4);
            if (tbl[k-2].pix > 4) begin
               tbl[k].ed = tbl[k-2].pix - 8'd4;
               tbl[k].cd = 1'b1;
            end else begin
               tbl[k].ed = '0;
               tbl[k].cd = L0_CHK;
            end
         end
      end

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.vld", int'(dout_vld), 0);
      chk("reset.cur", int'(dout_cur), 0);
      chk("reset.dly", int'(dout_dly), 0);
      chk("reset.first", int'(first_line), 1);

      for (int k = 0; k < tbl.size(); k++) begin
         cyc(1'b0, tbl[k].frm, tbl[k].vld, int'(tbl[k].pix));
         expect_out($sformatf("tbl%0d", k), tbl[k].ev, int'(tbl[k].ec), int'(tbl[k].ed),
                    tbl[k].ef, tbl[k].cd);
      end

      // frm_start at what would be column 2: pixel 20 becomes column 0 of line 0.
      cyc(1'b0, 1'b1, 1'b1, 1);
      cyc(1'b0, 1'b0, 1'b1, 2);
      cyc(1'b0, 1'b1, 1'b1, 20);
      expect_out("frm.c2", 1'b1, 1, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 21);
      expect_out("frm.c3", 1'b1, 2, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 22);
      expect_out("frm.p20", 1'b1, 20, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 23);
      expect_out("frm.p21", 1'b1, 21, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 24);
      expect_out("frm.p22", 1'b1, 22, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 25);
      expect_out("frm.p23", 1'b1, 23, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 26);
      expect_out("frm.p24", 1'b1, 24, 20, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 27);
      expect_out("frm.p25", 1'b1, 25, 21, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      expect_out("frm.p26", 1'b1, 26, 22, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      expect_out("frm.p27", 1'b1, 27, 23, 1'b0, 1'b1);

      // One-cycle reset mid-line (line 1, column 2), then restart without frm_start.
      cyc(1'b0, 1'b1, 1'b1, 1);
      cyc(1'b0, 1'b0, 1'b1, 2);
      cyc(1'b0, 1'b0, 1'b1, 3);
      cyc(1'b0, 1'b0, 1'b1, 4);
      cyc(1'b0, 1'b0, 1'b1, 5);
      cyc(1'b0, 1'b0, 1'b1, 6);
      cyc(1'b1, 1'b0, 1'b1, 7);
      expect_out("rst.pre", 1'b1, 5, 1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 30);
      chk("rst.vld", int'(dout_vld), 0);
      chk("rst.cur", int'(dout_cur), 0);
      chk("rst.dly", int'(dout_dly), 0);
      chk("rst.first", int'(first_line), 1);
      cyc(1'b0, 1'b0, 1'b1, 31);
      chk("rst.vld2", int'(dout_vld), 0);
      cyc(1'b0, 1'b0, 1'b1, 32);
      expect_out("rst.p30", 1'b1, 30, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 33);
      expect_out("rst.p31", 1'b1, 31, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 34);
      expect_out("rst.p32", 1'b1, 32, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 35);
      expect_out("rst.p33", 1'b1, 33, 0, 1'b1, L0_CHK);
      cyc(1'b0, 1'b0, 1'b1, 36);
      expect_out("rst.p34", 1'b1, 34, 30, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 37);
      expect_out("rst.p35", 1'b1, 35, 31, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      expect_out("rst.p36", 1'b1, 36, 32, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      expect_out("rst.p37", 1'b1, 37, 33, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 0);
      chk("rst.tail_vld", int'(dout_vld), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
